// File: rtl/systolic_pkg.sv
// Shared types and sizes for the 2x2 systolic array and its operand feeder.
package systolic_pkg;
  localparam int DATA_W     = 8;
  localparam int ACC_W      = 18;
  localparam int N          = 2;
  localparam int FEED_STEPS = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } feed_state_t;
endpackage

// File: rtl/systolic_feeder_2x2.sv
// Sequences one 2x2 matrix pair into the output-stationary array: clear, skewed feed,
// drain, capture the accumulators and hold the result until the consumer takes it.
module systolic_feeder_2x2
  import systolic_pkg::*;
#(
  parameter int DATA_W       = systolic_pkg::DATA_W,
  parameter int ACC_W        = systolic_pkg::ACC_W,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DATA_W-1:0] a_mat,
  input  logic [4*DATA_W-1:0] b_mat,
  output logic                arr_rst,
  output logic [DATA_W-1:0]   a1,
  output logic [DATA_W-1:0]   a2,
  output logic [DATA_W-1:0]   b1,
  output logic [DATA_W-1:0]   b2,
  input  logic [ACC_W-1:0]    c11,
  input  logic [ACC_W-1:0]    c12,
  input  logic [ACC_W-1:0]    c21,
  input  logic [ACC_W-1:0]    c22,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [4*ACC_W-1:0]  res,
  output feed_state_t         dbg_state
);
  localparam int DCW = $clog2(DRAIN_CYCLES + 1);

  feed_state_t         state, state_nxt;
  logic [1:0]          step, step_nxt;
  logic [DCW-1:0]      dcnt, dcnt_nxt;
  logic                capture;
  logic [4*DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0]   a1_nxt, a2_nxt, b1_nxt, b2_nxt;
  logic [4*ACC_W-1:0]  res_q;

  function automatic logic [DATA_W-1:0] elem(input logic [4*DATA_W-1:0] m, input int idx);
    return m[idx*DATA_W +: DATA_W];
  endfunction

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, res_valid only in DONE, and res never moves in DONE.
  assign in_ready  = (state == IDLE);
  assign res_valid = (state == DONE);
  assign arr_rst   = (state == CLEAR) || !rst;
  assign res       = res_q;
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    dcnt_nxt  = dcnt;
    capture   = 1'b0;
    case (state)
      IDLE:  if (in_valid) state_nxt = CLEAR;
      CLEAR: begin
        state_nxt = FEED;
        step_nxt  = 2'd0;
      end
      FEED: begin
        if (step == 2'(FEED_STEPS - 1)) begin
          state_nxt = DRAIN;
          dcnt_nxt  = '0;
        end else begin
          step_nxt = step + 2'd1;
        end
      end
      DRAIN: begin
        if (dcnt == DCW'(DRAIN_CYCLES - 1)) begin
          state_nxt = DONE;
          capture   = 1'b1;
        end else begin
          dcnt_nxt = dcnt + 1'b1;
        end
      end
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Operands are computed for the coming cycle so the array sees registered values.
    a1_nxt = '0;
    a2_nxt = '0;
    b1_nxt = '0;
    b2_nxt = '0;
    if (state_nxt == FEED) begin
      case (step_nxt)
        2'd0: begin
          a1_nxt = elem(a_q, 0);
          b1_nxt = elem(b_q, 0);
        end
        2'd1: begin
          a1_nxt = elem(a_q, 1);
          a2_nxt = elem(a_q, 2);
          b1_nxt = elem(b_q, 2);
          b2_nxt = elem(b_q, 1);
        end
        2'd2: begin
          a2_nxt = elem(a_q, 3);
          b2_nxt = elem(b_q, 3);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      step  <= '0;
      dcnt  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      a1    <= '0;
      a2    <= '0;
      b1    <= '0;
      b2    <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
      dcnt  <= dcnt_nxt;
      a1    <= a1_nxt;
      a2    <= a2_nxt;
      b1    <= b1_nxt;
      b2    <= b2_nxt;
      if (state == IDLE && in_valid) begin
        a_q <= a_mat;
        b_q <= b_mat;
      end
      if (capture) res_q <= {c22, c21, c12, c11};
    end
  end
endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Bench for systolic_feeder_2x2: drives jobs into the feeder wired to a behavioural
// 2x2 array, and checks every output each cycle against a job-level reference model.
module tb_systolic_feeder_2x2;
  import systolic_pkg::*;
  parameter int DRAIN = 4;
  localparam int DW = 8;
  localparam int AW = 18;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0, in_ready;
  logic [4*DW-1:0] a_mat = '0, b_mat = '0;
  logic            arr_rst;
  logic [DW-1:0]   a1, a2, b1, b2;
  logic [AW-1:0]   c11, c12, c21, c22;
  logic            res_valid, res_ready = 1'b0;
  logic [4*AW-1:0] res;
  feed_state_t     dbg_state;

  int n_tests = 0, n_fail = 0;

  systolic_feeder_2x2 #(.DATA_W(DW), .ACC_W(AW), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_mat(a_mat), .b_mat(b_mat), .arr_rst(arr_rst),
    .a1(a1), .a2(a2), .b1(b1), .b2(b2),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22),
    .res_valid(res_valid), .res_ready(res_ready), .res(res), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural output-stationary array driven by the feeder
  logic signed [AW-1:0] acc [4];
  logic signed [DW-1:0] a1d, a2d, b1d, b2d;
  always @(posedge clk) begin
    if (arr_rst) begin
      for (int i = 0; i < 4; i++) acc[i] <= '0;
      a1d <= '0; a2d <= '0; b1d <= '0; b2d <= '0;
    end else begin
      acc[0] <= acc[0] + $signed(a1) * $signed(b1);
      acc[1] <= acc[1] + a1d * $signed(b2);
      acc[2] <= acc[2] + $signed(a2) * b1d;
      acc[3] <= acc[3] + a2d * b2d;
      a1d <= a1; b1d <= b1; a2d <= a2; b2d <= b2;
    end
  end
  assign c11 = acc[0];
  assign c12 = acc[1];
  assign c21 = acc[2];
  assign c22 = acc[3];

  // reference model
  function automatic logic [4*AW-1:0] matmul(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b);
    int ma [2][2];
    int mb [2][2];
    logic [4*AW-1:0] r;
    logic [31:0] s;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        ma[i][j] = $signed(a[(i*2+j)*DW +: DW]);
        mb[i][j] = $signed(b[(i*2+j)*DW +: DW]);
      end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = ma[i][0] * mb[0][j] + ma[i][1] * mb[1][j];
        r[(i*2+j)*AW +: AW] = s[AW-1:0];
      end
    return r;
  endfunction

  logic [4*AW-1:0] exp_q[$];
  logic [4*DW-1:0] m_a, m_b;
  logic [4*AW-1:0] m_res = '0;
  int t = -1;          // cycles since accept (1 = clear cycle), -1 when idle
  int cyc = 0, acc_cyc = 0;
  bit started = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      started = 1;
      t = -1;
      m_res = '0;
      exp_q.delete();
    end else if (t < 0) begin
      if (in_valid) begin
        m_a = a_mat;
        m_b = b_mat;
        exp_q.push_back(matmul(a_mat, b_mat));
        acc_cyc = cyc;
        t = 1;
      end
    end else if (t == 5 + DRAIN) begin
      if (res_ready) begin
        void'(exp_q.pop_front());
        t = -1;
      end
    end else begin
      t++;
      if (t == 5 + DRAIN) m_res = exp_q[0];
    end
  end

  // Skewed streams: row r sees A[r][s-r] at feed step s, column c sees B[s-c][c].
  function automatic logic [DW-1:0] a_stream(input int r, input int tt);
    int s = tt - 2;
    if (tt < 2 || tt > 4 || s - r < 0 || s - r > 1) return '0;
    return m_a[(r*2 + (s-r))*DW +: DW];
  endfunction
  function automatic logic [DW-1:0] b_stream(input int c, input int tt);
    int s = tt - 2;
    if (tt < 2 || tt > 4 || s - c < 0 || s - c > 1) return '0;
    return m_b[((s-c)*2 + c)*DW +: DW];
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  // per-cycle compare
  logic rv_prev = 1'b0;
  always @(negedge clk) begin
    if (started) begin
      check("in_ready", in_ready, t < 0);
      check("res_valid", res_valid, t == 5 + DRAIN);
      check("arr_rst", arr_rst, !rst || t == 1);
      check("a1", a1, a_stream(0, t));
      check("a2", a2, a_stream(1, t));
      check("b1", b1, b_stream(0, t));
      check("b2", b2, b_stream(1, t));
      check("res", res, m_res);
      if (res_valid && !rv_prev) check("latency", cyc - acc_cyc, 4 + DRAIN);
      rv_prev = res_valid;
    end
  end

  // driver
  task automatic run_job(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b,
                         input int hold, input bit poke, output logic [4*AW-1:0] got_res);
    bit got;
    @(posedge clk); #1;
    a_mat = a; b_mat = b; in_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1;
    end
    check("accept_timeout", got, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; a_mat = $urandom; b_mat = $urandom;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (res_valid) got = 1;
    end
    check("result_timeout", got, 1);
    got_res = res;
    if (poke) in_valid = 1'b1;
    repeat (hold) @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0; in_valid = 1'b0;
  endtask

  localparam logic [31:0] BA = 32'h04030201;
  localparam logic [31:0] BB = 32'h08070605;
  localparam logic [31:0] ID = 32'h01000001;
  localparam logic [31:0] M128 = 32'h80808080;
  localparam logic [31:0] P127 = 32'h7f7f7f7f;
  localparam logic [AW-1:0] NEG = 18'h38100;

  initial begin
    logic [4*AW-1:0] r;
    logic [4*AW-1:0] basic_c;
    basic_c = {18'd50, 18'd43, 18'd22, 18'd19};
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    check("model_pin", matmul(BA, BB), basic_c);
    run_job(BA, BB, 0, 0, r);   check("basic", r, basic_c);
    run_job(ID, BB, 0, 0, r);   check("b2b_identity", r, {18'd8, 18'd7, 18'd6, 18'd5});
    run_job(M128, M128, 0, 0, r); check("neg_extreme", r, {4{18'd32768}});
    run_job(P127, M128, 0, 0, r); check("mixed_extreme", r, {4{NEG}});
    run_job(BA, BB, 6, 1, r);   check("backpressure", r, basic_c);

    // reset while the feeder is in feed step 1
    @(posedge clk); #1;
    a_mat = BA; b_mat = BB; in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_feed_state", dbg_state, FEED);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    run_job(BA, BB, 0, 0, r);   check("after_reset", r, basic_c);

    for (int k = 0; k < 10; k++)
      run_job($urandom, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), r);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
